// File: rtl/decode_stage.sv
// decode_stage
//
// Instruction-decode pipeline stage. It sits between the IF/ID register and
// the execute stage and contains:
//   - a REG_COUNT x DATA_W register file with a write-first bypass from the
//     write-back port,
//   - an immediate extension unit (sign, zero, sign<<2, upper placement),
//   - load-use hazard detection against the instruction held in ID/EX,
//   - the ID/EX pipeline register with valid/ready stall and flush.
//
// Ports:
//   clk, reset                        clock (rising edge), async active-low reset
//   valid_in, rs, rt, rd, imm         decode instruction and its fields
//   ext_mode                          00 sext, 01 zext, 10 sext<<2, 11 imm in upper bits
//   reg_dst, reg_write,
//   mem_read, mem_write               control bits for the decode instruction
//   wb_en, wb_addr, wb_data           write-back port into the register file
//   flush                             kill the decode instruction and ID/EX contents
//   ex_ready                          execute accepts ID/EX contents this cycle
//   id_ready                          decode instruction is consumed this cycle
//   ex_*                              registered operand/control bundle to execute
//   hazard                            load-use stall indicator (combinational)
module decode_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int IMM_W     = 16,
  parameter bit ZERO_REG  = 1'b1,
  localparam int ADDR_W   = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        ext_mode,
  input  logic              reg_dst,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              id_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rd_data1,
  output logic [DATA_W-1:0] ex_rd_data2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_dest,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              hazard
);

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_SHIFT = 2'b10,
    EXT_UPPER = 2'b11
  } ext_mode_e;

  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] imm_sext;
  logic [ADDR_W-1:0] dest;
  logic              wr_en;
  logic              advance;

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  assign wr_en = wb_en && !(ZERO_REG && (wb_addr == '0));

  // NOTE: the storage array is reset along with the pipeline registers because
  // no architectural state may survive a reset; a memory that needs no reset
  // would leave this out so it can map onto RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      regs[wb_addr] <= wb_data;
    end
  end

  // Write-first bypass: a write landing this edge is already visible to the
  // reads of this cycle. Address 0 never bypasses.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    rd_data1 = regs[rs];
    if (ZERO_REG && (rs == '0)) begin
      rd_data1 = '0;
    end else if (wb_en && (wb_addr == rs) && (rs != '0)) begin
      rd_data1 = wb_data;
    end
  end

  always_comb begin
    rd_data2 = regs[rt];
    if (ZERO_REG && (rt == '0)) begin
      rd_data2 = '0;
    end else if (wb_en && (wb_addr == rt) && (rt != '0)) begin
      rd_data2 = wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Immediate extension
  // ---------------------------------------------------------------------------
  assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  always_comb begin
    imm_ext = imm_sext;
    case (ext_mode_e'(ext_mode))
      EXT_SIGN:  imm_ext = imm_sext;
      EXT_ZERO:  imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_SHIFT: imm_ext = imm_sext << 2;   // top two bits fall off
      EXT_UPPER: imm_ext = {imm, {(DATA_W-IMM_W){1'b0}}};
      default:   imm_ext = imm_sext;
    endcase
  end

  assign dest = reg_dst ? rd : rt;

  // ---------------------------------------------------------------------------
  // Hazard detection and handshake
  // ---------------------------------------------------------------------------
  // A load in ID/EX whose destination feeds this instruction must not be
  // bypassed from execute: its data only exists after memory.
  assign hazard = valid_in && ex_valid && ex_mem_read && (ex_dest != '0) &&
                  ((ex_dest == rs) || (ex_dest == rt));

  assign advance = ex_ready || !ex_valid;

  // A flushed instruction counts as consumed: it is discarded, not stalled.
  assign id_ready = reset && (flush || (advance && !hazard));

  // ---------------------------------------------------------------------------
  // ID/EX pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_rd_data1  <= '0;
      ex_rd_data2  <= '0;
      ex_imm       <= '0;
      ex_dest      <= '0;
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance && hazard) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      // The bundle loads even for an invalid slot; execute qualifies it with
      // ex_valid, which keeps the data path free of enable gating.
      ex_valid     <= valid_in;
      ex_rd_data1  <= rd_data1;
      ex_rd_data2  <= rd_data2;
      ex_imm       <= imm_ext;
      ex_dest      <= dest;
      ex_rs        <= rs;
      ex_rt        <= rt;
      ex_reg_write <= reg_write;
      ex_mem_read  <= mem_read;
      ex_mem_write <= mem_write;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage (default parameters). Expected bundles
// are pushed to a scoreboard queue when an instruction is driven and popped
// when ex_valid shows it in the ID/EX register.
module tb_decode_stage;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int IMM_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [IMM_W-1:0]  imm;
  logic [1:0]        ext_mode;
  logic              reg_dst, reg_write, mem_read, mem_write;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush, ex_ready;
  logic              id_ready, ex_valid, hazard;
  logic [DATA_W-1:0] ex_rd_data1, ex_rd_data2, ex_imm;
  logic [ADDR_W-1:0] ex_dest, ex_rs, ex_rt;
  logic              ex_reg_write, ex_mem_read, ex_mem_write;

  decode_stage dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .imm          (imm),
    .ext_mode     (ext_mode),
    .reg_dst      (reg_dst),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .flush        (flush),
    .ex_ready     (ex_ready),
    .id_ready     (id_ready),
    .ex_valid     (ex_valid),
    .ex_rd_data1  (ex_rd_data1),
    .ex_rd_data2  (ex_rd_data2),
    .ex_imm       (ex_imm),
    .ex_dest      (ex_dest),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .hazard       (hazard)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm_x;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] rs_x;
    logic [ADDR_W-1:0] rt_x;
    logic              rw;
    logic              mr;
    logic              mw;
  } bundle_t;

  bundle_t sb[$];
  bundle_t last_exp;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] t,
                       input logic [ADDR_W-1:0] d, input logic [IMM_W-1:0] im,
                       input logic [1:0] mode, input logic rdst, input logic rw,
                       input logic mr, input logic mw);
    valid_in  = v;
    rs        = s;
    rt        = t;
    rd        = d;
    imm       = im;
    ext_mode  = mode;
    reg_dst   = rdst;
    reg_write = rw;
    mem_read  = mr;
    mem_write = mw;
  endtask

  // Expected bundle for the instruction currently driven; operand values,
  // immediate and destination are supplied by the caller.
  task automatic push_exp(input logic [DATA_W-1:0] rd1, input logic [DATA_W-1:0] rd2,
                          input logic [DATA_W-1:0] imm_x, input logic [ADDR_W-1:0] dest);
    bundle_t e;
    e.rd1   = rd1;
    e.rd2   = rd2;
    e.imm_x = imm_x;
    e.dest  = dest;
    e.rs_x  = rs;
    e.rt_x  = rt;
    e.rw    = reg_write;
    e.mr    = mem_read;
    e.mw    = mem_write;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    bundle_t e;
    check({tag, ".ex_valid"}, 64'(ex_valid), 64'(1));
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: ex output with no expected entry", tag);
    end else begin
      e = sb.pop_front();
      last_exp = e;
      check({tag, ".rd1"},  64'(ex_rd_data1),  64'(e.rd1));
      check({tag, ".rd2"},  64'(ex_rd_data2),  64'(e.rd2));
      check({tag, ".imm"},  64'(ex_imm),       64'(e.imm_x));
      check({tag, ".dest"}, 64'(ex_dest),      64'(e.dest));
      check({tag, ".rs"},   64'(ex_rs),        64'(e.rs_x));
      check({tag, ".rt"},   64'(ex_rt),        64'(e.rt_x));
      check({tag, ".rw"},   64'(ex_reg_write), 64'(e.rw));
      check({tag, ".mr"},   64'(ex_mem_read),  64'(e.mr));
      check({tag, ".mw"},   64'(ex_mem_write), 64'(e.mw));
    end
  endtask

  task automatic wb_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    tick();
    wb_en   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    flush = 1'b0; ex_ready = 1'b1;

    // Reset state
    #1;
    check("reset.id_ready", 64'(id_ready), 64'(0));
    check("reset.ex_valid", 64'(ex_valid), 64'(0));
    check("reset.ex_rd_data1", 64'(ex_rd_data1), 64'(0));
    tick(); tick();
    reset = 1'b1;
    tick();

    // Register contents used below: r1=9, r3=7, r4=44, r5=55
    wb_write(5'd1, 32'd9);
    wb_write(5'd3, 32'd7);
    wb_write(5'd4, 32'd44);
    wb_write(5'd5, 32'd55);
    check("idle.ex_valid", 64'(ex_valid), 64'(0));

    // Bypass from write-back, plus sign extension
    drive(1'b1, 5'd2, 5'd1, 5'd0, 16'h8081, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd25;
    #1;
    check("bypass.id_ready", 64'(id_ready), 64'(1));
    check("bypass.hazard", 64'(hazard), 64'(0));
    push_exp(32'd25, 32'd9, 32'hFFFF_8081, 5'd1);
    tick();
    wb_en = 1'b0;
    pop_check("bypass");

    // Remaining extension modes (r2 now read from storage)
    drive(1'b1, 5'd2, 5'd0, 5'd0, 16'h8081, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(32'd25, 32'd0, 32'h0000_8081, 5'd0);
    tick(); pop_check("ext_zero");
    drive(1'b1, 5'd3, 5'd0, 5'd0, 16'h8081, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(32'd7, 32'd0, 32'hFFFE_0204, 5'd0);
    tick(); pop_check("ext_shift");
    drive(1'b1, 5'd3, 5'd0, 5'd0, 16'h8081, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(32'd7, 32'd0, 32'h8081_0000, 5'd0);
    tick(); pop_check("ext_upper");

    // Load-use: load into r5, then a consumer of r5
    drive(1'b1, 5'd1, 5'd5, 5'd0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(32'd9, 32'd55, 32'd0, 5'd5);
    tick(); pop_check("load");
    drive(1'b1, 5'd5, 5'd1, 5'd0, 16'h0004, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check("loaduse.hazard", 64'(hazard), 64'(1));
    check("loaduse.id_ready", 64'(id_ready), 64'(0));
    tick();
    check("bubble.ex_valid", 64'(ex_valid), 64'(0));
    check("bubble.hazard", 64'(hazard), 64'(0));
    check("bubble.id_ready", 64'(id_ready), 64'(1));
    push_exp(32'd55, 32'd9, 32'd4, 5'd1);
    tick(); pop_check("after_bubble");

    // Downstream stall for three cycles, then flush
    drive(1'b1, 5'd3, 5'd1, 5'd0, 16'h0042, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    push_exp(32'd7, 32'd9, 32'h42, 5'd1);
    tick(); pop_check("pre_stall");
    ex_ready = 1'b0;
    drive(1'b1, 5'd2, 5'd2, 5'd0, 16'h1111, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall.id_ready", 64'(id_ready), 64'(0));
      tick();
      check("stall.ex_valid", 64'(ex_valid), 64'(1));
      check("stall.rd1", 64'(ex_rd_data1), 64'(last_exp.rd1));
      check("stall.imm", 64'(ex_imm), 64'(last_exp.imm_x));
      check("stall.mw", 64'(ex_mem_write), 64'(last_exp.mw));
    end
    flush = 1'b1;
    #1;
    check("stall_flush.id_ready", 64'(id_ready), 64'(1));
    tick();
    flush = 1'b0;
    check("stall_flush.ex_valid", 64'(ex_valid), 64'(0));
    check("stall_flush.imm_kept", 64'(ex_imm), 64'(last_exp.imm_x));
    ex_ready = 1'b1;

    // Zero register: write to r0 is dropped and never bypassed
    drive(1'b1, 5'd0, 5'd4, 5'd4, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'd123;
    push_exp(32'd0, 32'd44, 32'd0, 5'd4);
    tick();
    wb_en = 1'b0;
    pop_check("r0_bypass");
    push_exp(32'd0, 32'd44, 32'd0, 5'd4);
    tick(); pop_check("r0_stored");

    // Simultaneous flush and hazard: flush wins, instruction discarded
    drive(1'b1, 5'd1, 5'd5, 5'd0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    push_exp(32'd9, 32'd55, 32'd0, 5'd5);
    tick(); pop_check("load2");
    drive(1'b1, 5'd5, 5'd0, 5'd0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_hazard.hazard", 64'(hazard), 64'(1));
    check("flush_hazard.id_ready", 64'(id_ready), 64'(1));
    tick();
    flush = 1'b0;
    check("flush_hazard.ex_valid", 64'(ex_valid), 64'(0));

    // Reset mid-cycle with a valid bundle in ID/EX
    drive(1'b1, 5'd3, 5'd1, 5'd0, 16'h0001, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    push_exp(32'd7, 32'd9, 32'd1, 5'd1);
    tick(); pop_check("pre_reset");
    #2;
    reset = 1'b0;
    #1;
    check("midreset.ex_valid", 64'(ex_valid), 64'(0));
    check("midreset.rd1", 64'(ex_rd_data1), 64'(0));
    check("midreset.rd2", 64'(ex_rd_data2), 64'(0));
    check("midreset.imm", 64'(ex_imm), 64'(0));
    check("midreset.rw", 64'(ex_reg_write), 64'(0));
    check("midreset.id_ready", 64'(id_ready), 64'(0));
    #2;
    reset = 1'b1;
    push_exp(32'd0, 32'd0, 32'd1, 5'd1);
    tick(); pop_check("post_reset_r3");

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised instruction-decode pipeline stage: register file with write-back bypass, immediate extension unit, load-use hazard detection, and the ID/EX pipeline register with valid/ready stall and flush. It sits between the IF/ID register and the execute stage. It takes decoded fields plus control bits from `ControlUnit`, and hands a registered operand/control bundle to execute.

## Interface
- `DATA_W`, 32: register and operand width (≥ IMM_W+2).
- `REG_COUNT`, 32: number of architectural registers; power of two ≥ 2; `ADDR_W = $clog2(REG_COUNT)`.
- `IMM_W`, 16: instruction immediate field width.
- `ZERO_REG`, 1: if 1, register 0 reads as 0 and ignores writes.

- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_in`  in  1  decode-stage instruction valid.
- `rs`, `rt`, `rd`  in  ADDR_W each  source/destination register fields.
- `imm`  in  IMM_W  immediate field.
- `ext_mode`  in  2  00 sign-ext, 01 zero-ext, 10 sign-ext then <<2, 11 imm placed in upper bits, low bits zero.
- `reg_dst`, `reg_write`, `mem_read`, `mem_write`  in  1 each  control bits for the decode instruction.
- `wb_en`  in  1, `wb_addr`  in  ADDR_W, `wb_data`  in  DATA_W  write-back port.
- `flush`  in  1  kill the decode instruction and the ID/EX contents.
- `ex_ready`  in  1  execute accepts ID/EX contents this cycle.
- `id_ready`  out  1  decode instruction is consumed this cycle.
- `ex_valid`  out  1; `ex_rd_data1`, `ex_rd_data2`, `ex_imm`  out  DATA_W; `ex_dest`, `ex_rs`, `ex_rt`  out  ADDR_W; `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1 each.
- `hazard`  out  1  load-use stall indicator.

## Operation
- Register file: REG_COUNT × DATA_W. Write on rising edge when `wb_en` and not (ZERO_REG and `wb_addr`==0).
- Reads are combinational on `rs`/`rt`. If `wb_en` and the write address matches a non-zero read address, the read returns `wb_data` (write-first bypass).
- Address 0 reads 0 when ZERO_REG=1.
- Extension per `ext_mode`. Mode 10 is computed as sign-ext(imm)<<2 truncated to DATA_W. Mode 11 is imm in bits [DATA_W-1:DATA_W-IMM_W], zeros below.
- `ex_dest` source: `rd` when `reg_dst`=1, else `rt`.
- `hazard` = `valid_in` & `ex_valid` & `ex_mem_read` & (`ex_dest`≠0) & (`ex_dest`==`rs` | `ex_dest`==`rt`).
- `advance` = `ex_ready` | ~`ex_valid`.
- `id_ready` = reset deasserted & (`flush` | (`advance` & ~`hazard`)).
- Rising-edge priority for the ID/EX register:
  - `flush`: `ex_valid`←0, bundle unchanged.
  - else `advance` & `hazard`: `ex_valid`←0 (bubble).
  - else `advance`: `ex_valid`←`valid_in`; all bundle fields load from the current decode values.
  - else: hold all.
- With `valid_in`=0 on advance, the bundle still loads and `ex_valid`=0. Execute must ignore the bundle when `ex_valid`=0.

## Timing
- Reset low, asynchronous: all registers, `ex_*` outputs and the register file go to 0, and `id_ready`=0 at once. This holds mid-stall and mid-flush; no state survives.
- First edge after reset release operates normally.
- Latency: an instruction accepted at edge N appears on `ex_*` after edge N.
- A write-back at edge N is visible combinationally in cycle N through the bypass, and from storage afterwards.
- Load-use costs exactly one bubble: the bubble edge clears `ex_valid`, so `hazard` drops and the instruction issues on the next advancing edge.
- Downstream stall (`ex_ready`=0, `ex_valid`=1): ex outputs are held bit-exact and `id_ready`=0.
- `flush` during a stall still clears `ex_valid` at the next edge.
- Simultaneous `flush` and `hazard`: flush wins, and `id_ready`=1 (the instruction is discarded).
- `hazard`, `id_ready` and read data are combinational; all `ex_*` outputs are registered.

## Test plan
- Reset: load ex with `ex_valid`=1 and r3=7, then drive `reset` low mid-cycle → immediately all `ex_*`=0 and `id_ready`=0; after release, reading r3 gives 0.
- Bypass: `wb_en`=1, `wb_addr`=2, `wb_data`=25, `rs`=2, `rt`=1 (r1=9), `valid_in`=1, `ex_ready`=1 → next cycle `ex_rd_data1`=25, `ex_rd_data2`=9.
- Extension: `imm`=16'h8081 with modes 00/01/10/11 → `ex_imm` = FFFF8081 / 00008081 / FFFE0204 / 80810000.
- Load-use: ex holds `mem_read`=1, `ex_dest`=5; decode `rs`=5 with `valid_in`=1 → `hazard`=1 and `id_ready`=0 for one cycle, a bubble enters ex, then the instruction issues with `id_ready`=1.
- Stall and flush: `ex_ready`=0 for 3 cycles → ex outputs constant and `id_ready`=0; then `flush`=1 → `ex_valid`=0 next edge.
- Zero register: write 123 to r0 → reading r0 gives 0, with no bypass; with `reg_dst`=1 and `rd`=4, `ex_dest`=4.
